// File: rtl/alu_reservation_station.sv
// Integer ALU reservation station: buffers dispatched micro-ops, snoops the CDB
// for missing operands and issues the lowest-index ready entry each cycle.
module alu_reservation_station #(
  parameter int BIT_WIDTH   = 64,
  parameter int NUM_ENTRIES = 8,
  parameter int TAG_WIDTH   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 dispatch_valid,
  output logic                 dispatch_ready,
  input  logic [3:0]           dispatch_opCode,
  input  logic                 dispatch_src1_rdy,
  input  logic                 dispatch_src2_rdy,
  input  logic [BIT_WIDTH-1:0] dispatch_src1_val,
  input  logic [BIT_WIDTH-1:0] dispatch_src2_val,
  input  logic [TAG_WIDTH-1:0] dispatch_src1_tag,
  input  logic [TAG_WIDTH-1:0] dispatch_src2_tag,
  input  logic [TAG_WIDTH-1:0] dispatch_dest_tag,
  input  logic                 cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic [BIT_WIDTH-1:0] cdb_data,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [BIT_WIDTH-1:0] issue_in1,
  output logic [BIT_WIDTH-1:0] issue_in2,
  output logic [3:0]           issue_opCode,
  output logic [TAG_WIDTH-1:0] issue_dest_tag
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] ent_valid;
  logic [NUM_ENTRIES-1:0] src1_rdy;
  logic [NUM_ENTRIES-1:0] src2_rdy;
  logic [3:0]             ent_op   [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   ent_dest [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   src1_tag [NUM_ENTRIES];
  logic [TAG_WIDTH-1:0]   src2_tag [NUM_ENTRIES];
  logic [BIT_WIDTH-1:0]   src1_val [NUM_ENTRIES];
  logic [BIT_WIDTH-1:0]   src2_val [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] eligible;
  logic [NUM_ENTRIES-1:0] wake1;
  logic [NUM_ENTRIES-1:0] wake2;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       iss_idx;
  logic                   free_any;
  logic                   iss_any;
  logic                   dispatch_accept;
  logic                   issue_fire;
  logic                   disp_byp1;
  logic                   disp_byp2;

  assign eligible = ent_valid & src1_rdy & src2_rdy;
  assign free_any = ~&ent_valid;
  assign iss_any  = |eligible;

  // Lowest-index free slot and lowest-index eligible slot.
  always_comb begin
    free_idx = '0;
    iss_idx  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!ent_valid[i]) free_idx = IDX_W'(i);
      if (eligible[i])   iss_idx  = IDX_W'(i);
    end
  end

  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      wake1[i] = cdb_valid && !src1_rdy[i] && (src1_tag[i] == cdb_tag);
      wake2[i] = cdb_valid && !src2_rdy[i] && (src2_tag[i] == cdb_tag);
    end
  end

  assign disp_byp1 = !dispatch_src1_rdy && cdb_valid && (dispatch_src1_tag == cdb_tag);
  assign disp_byp2 = !dispatch_src2_rdy && cdb_valid && (dispatch_src2_tag == cdb_tag);

  // Readiness comes from registered occupancy only, so a slot freed by this
  // cycle's issue is not offered to dispatch until the next cycle.
  assign dispatch_ready  = free_any && !reset;
  assign issue_valid     = iss_any && !reset;
  assign dispatch_accept = dispatch_valid && dispatch_ready && !flush;
  assign issue_fire      = issue_valid && issue_ready && !flush;

  assign issue_in1      = src1_val[iss_idx];
  assign issue_in2      = src2_val[iss_idx];
  assign issue_opCode   = ent_op[iss_idx];
  assign issue_dest_tag = ent_dest[iss_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid <= '0;
    end else if (flush) begin
      ent_valid <= '0;
    end else begin
      if (issue_fire)      ent_valid[iss_idx]  <= 1'b0;
      if (dispatch_accept) ent_valid[free_idx] <= 1'b1;
    end
  end

  // Payload carries no reset; it is only meaningful while the entry is valid.
  // The dispatched slot is always invalid, so it never collides with a wakeup.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ent_valid[i] && wake1[i]) begin
        src1_rdy[i] <= 1'b1;
        src1_val[i] <= cdb_data;
      end
      if (ent_valid[i] && wake2[i]) begin
        src2_rdy[i] <= 1'b1;
        src2_val[i] <= cdb_data;
      end
    end
    if (dispatch_accept) begin
      ent_op[free_idx]   <= dispatch_opCode;
      ent_dest[free_idx] <= dispatch_dest_tag;
      src1_tag[free_idx] <= dispatch_src1_tag;
      src2_tag[free_idx] <= dispatch_src2_tag;
      src1_rdy[free_idx] <= dispatch_src1_rdy || disp_byp1;
      src2_rdy[free_idx] <= dispatch_src2_rdy || disp_byp2;
      src1_val[free_idx] <= dispatch_src1_rdy ? dispatch_src1_val : cdb_data;
      src2_val[free_idx] <= dispatch_src2_rdy ? dispatch_src2_val : cdb_data;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_alu_reservation_station;

  localparam int BW = 64;
  localparam int NE = 8;
  localparam int TW = 6;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  logic          clk = 1'b0;
  logic          reset, flush;
  logic          dispatch_valid, dispatch_ready;
  logic [3:0]    dispatch_opCode;
  logic          dispatch_src1_rdy, dispatch_src2_rdy;
  logic [BW-1:0] dispatch_src1_val, dispatch_src2_val;
  logic [TW-1:0] dispatch_src1_tag, dispatch_src2_tag, dispatch_dest_tag;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [BW-1:0] cdb_data;
  logic          issue_valid, issue_ready;
  logic [BW-1:0] issue_in1, issue_in2;
  logic [3:0]    issue_opCode;
  logic [TW-1:0] issue_dest_tag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_reservation_station #(.BIT_WIDTH(BW), .NUM_ENTRIES(NE), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_opCode(dispatch_opCode),
    .dispatch_src1_rdy(dispatch_src1_rdy), .dispatch_src2_rdy(dispatch_src2_rdy),
    .dispatch_src1_val(dispatch_src1_val), .dispatch_src2_val(dispatch_src2_val),
    .dispatch_src1_tag(dispatch_src1_tag), .dispatch_src2_tag(dispatch_src2_tag),
    .dispatch_dest_tag(dispatch_dest_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_in1(issue_in1), .issue_in2(issue_in2),
    .issue_opCode(issue_opCode), .issue_dest_tag(issue_dest_tag)
  );

  // Behavioural model: a table of buffered micro-ops.
  typedef struct {
    bit            v;
    logic [3:0]    op;
    logic [TW-1:0] dest;
    bit            r1, r2;
    logic [BW-1:0] v1, v2;
    logic [TW-1:0] t1, t2;
  } ent_t;

  ent_t m[NE];

  function automatic int m_issue_idx();
    for (int i = 0; i < NE; i++)
      if (m[i].v && m[i].r1 && m[i].r2) return i;
    return -1;
  endfunction

  function automatic int m_free_idx();
    for (int i = 0; i < NE; i++)
      if (!m[i].v) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int fi, ii;
    fi = m_free_idx();
    ii = m_issue_idx();
    if (reset || flush) begin
      for (int i = 0; i < NE; i++) m[i].v = 0;
    end else begin
      for (int i = 0; i < NE; i++) begin
        if (m[i].v && cdb_valid && !m[i].r1 && m[i].t1 == cdb_tag) begin m[i].r1 = 1; m[i].v1 = cdb_data; end
        if (m[i].v && cdb_valid && !m[i].r2 && m[i].t2 == cdb_tag) begin m[i].r2 = 1; m[i].v2 = cdb_data; end
      end
      if (ii >= 0 && issue_ready) m[ii].v = 0;
      if (dispatch_valid && fi >= 0) begin
        m[fi].v    = 1;
        m[fi].op   = dispatch_opCode;
        m[fi].dest = dispatch_dest_tag;
        m[fi].t1   = dispatch_src1_tag;
        m[fi].t2   = dispatch_src2_tag;
        m[fi].r1   = dispatch_src1_rdy || (cdb_valid && cdb_tag == dispatch_src1_tag);
        m[fi].r2   = dispatch_src2_rdy || (cdb_valid && cdb_tag == dispatch_src2_tag);
        m[fi].v1   = dispatch_src1_rdy ? dispatch_src1_val : cdb_data;
        m[fi].v2   = dispatch_src2_rdy ? dispatch_src2_val : cdb_data;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NE; i++) m[i].v = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      int ii;
      @(negedge clk);
      ii = m_issue_idx();
      chk("cmp_dispatch_ready", {63'd0, dispatch_ready}, {63'd0, (!reset && m_free_idx() >= 0)});
      chk("cmp_issue_valid", {63'd0, issue_valid}, {63'd0, (!reset && ii >= 0)});
      if (!reset && ii >= 0) begin
        chk("cmp_issue_in1", issue_in1, m[ii].v1);
        chk("cmp_issue_in2", issue_in2, m[ii].v2);
        chk("cmp_issue_op", {60'd0, issue_opCode}, {60'd0, m[ii].op});
        chk("cmp_issue_dest", {58'd0, issue_dest_tag}, {58'd0, m[ii].dest});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; flush = 0; dispatch_valid = 0; issue_ready = 0; cdb_valid = 0;
    cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic disp(input logic [3:0] op, input bit r1, input logic [BW-1:0] v1, input logic [TW-1:0] t1,
                      input bit r2, input logic [BW-1:0] v2, input logic [TW-1:0] t2, input logic [TW-1:0] d);
    dispatch_valid = 1; dispatch_opCode = op;
    dispatch_src1_rdy = r1; dispatch_src1_val = v1; dispatch_src1_tag = t1;
    dispatch_src2_rdy = r2; dispatch_src2_val = v2; dispatch_src2_tag = t2;
    dispatch_dest_tag = d;
  endtask

  task automatic at_check();
    #5;
  endtask

  initial begin
    idle();
    disp(ALU_ADD, 1, 64'd1, 6'd0, 1, 64'd2, 6'd0, 6'd1);
    reset = 1;
    tick(); tick();
    at_check();
    chk("rst_dispatch_ready", {63'd0, dispatch_ready}, 64'd0);
    chk("rst_issue_valid", {63'd0, issue_valid}, 64'd0);

    tick(); idle();
    at_check();
    chk("post_rst_dispatch_ready", {63'd0, dispatch_ready}, 64'd1);
    chk("post_rst_issue_valid", {63'd0, issue_valid}, 64'd0);

    // Fully ready ADD issues the cycle after dispatch.
    tick(); disp(ALU_ADD, 1, 64'd5, 6'd0, 1, 64'd7, 6'd0, 6'd3);
    tick(); idle(); issue_ready = 1;
    at_check();
    chk("add_issue_valid", {63'd0, issue_valid}, 64'd1);
    chk("add_in1", issue_in1, 64'd5);
    chk("add_in2", issue_in2, 64'd7);
    chk("add_op", {60'd0, issue_opCode}, {60'd0, ALU_ADD});
    chk("add_dest", {58'd0, issue_dest_tag}, 64'd3);
    chk("model_pin_add_dest", {58'd0, m[m_issue_idx()].dest}, 64'd3);
    tick(); idle();
    at_check();
    chk("add_freed", {63'd0, issue_valid}, 64'd0);

    // SUB waiting on tag 9, woken by the CDB two cycles later.
    tick(); disp(ALU_SUB, 1, 64'd1, 6'd0, 0, 64'd0, 6'd9, 6'd4);
    tick(); idle();
    at_check();
    chk("sub_wait_valid", {63'd0, issue_valid}, 64'd0);
    tick(); cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 64'h10;
    at_check();
    chk("sub_bcast_cycle_valid", {63'd0, issue_valid}, 64'd0);
    tick(); idle(); issue_ready = 1;
    at_check();
    chk("sub_issue_valid", {63'd0, issue_valid}, 64'd1);
    chk("sub_in2", issue_in2, 64'h10);
    chk("sub_op", {60'd0, issue_opCode}, {60'd0, ALU_SUB});
    chk("model_pin_sub_in2", m[m_issue_idx()].v2, 64'h10);

    // Dispatch-cycle CDB bypass.
    tick(); idle();
    disp(ALU_ADD, 0, 64'd0, 6'd4, 1, 64'd2, 6'd0, 6'd5);
    cdb_valid = 1; cdb_tag = 6'd4; cdb_data = 64'hAA;
    tick(); idle(); issue_ready = 1;
    at_check();
    chk("byp_issue_valid", {63'd0, issue_valid}, 64'd1);
    chk("byp_in1", issue_in1, 64'hAA);
    chk("byp_dest", {58'd0, issue_dest_tag}, 64'd5);

    // Fill all entries; entries 2 and 5 wait on tag 20.
    tick(); idle();
    for (int i = 0; i < NE; i++) begin
      disp(ALU_ADD, 0, 64'd0, (i == 2 || i == 5) ? 6'd20 : TW'(30 + i), 1, 64'(i), 6'd0, TW'(i));
      tick();
    end
    idle();
    at_check();
    chk("full_dispatch_ready", {63'd0, dispatch_ready}, 64'd0);
    tick(); cdb_valid = 1; cdb_tag = 6'd20; cdb_data = 64'h55;
    tick(); idle(); issue_ready = 1;
    at_check();
    chk("full_issue2_valid", {63'd0, issue_valid}, 64'd1);
    chk("full_issue2_dest", {58'd0, issue_dest_tag}, 64'd2);
    chk("full_issue2_in1", issue_in1, 64'h55);
    chk("full_issue2_dready", {63'd0, dispatch_ready}, 64'd0);
    tick(); issue_ready = 1;
    at_check();
    chk("full_issue5_dest", {58'd0, issue_dest_tag}, 64'd5);
    chk("full_issue5_dready", {63'd0, dispatch_ready}, 64'd1);

    // Clear, load 4 ready ops, then flush together with dispatch and issue.
    tick(); idle(); flush = 1;
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      disp(ALU_ADD, 1, 64'(i), 6'd0, 1, 64'd1, 6'd0, TW'(40 + i));
      tick();
    end
    idle(); flush = 1; issue_ready = 1;
    disp(ALU_SUB, 1, 64'd9, 6'd0, 1, 64'd9, 6'd0, 6'd50);
    at_check();
    chk("flush_cycle_issue_valid", {63'd0, issue_valid}, 64'd1);
    chk("flush_cycle_dest", {58'd0, issue_dest_tag}, 64'd40);
    tick(); idle();
    at_check();
    chk("post_flush_issue_valid", {63'd0, issue_valid}, 64'd0);
    chk("post_flush_dready", {63'd0, dispatch_ready}, 64'd1);

    // Randomized traffic; small tag space so wakeups hit frequently.
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset             = ($urandom_range(0, 255) == 0);
      flush             = ($urandom_range(0, 63) == 0);
      dispatch_valid    = ($urandom_range(0, 1) == 1);
      dispatch_opCode   = 4'($urandom_range(0, 15));
      dispatch_src1_rdy = ($urandom_range(0, 2) == 0);
      dispatch_src2_rdy = ($urandom_range(0, 2) == 0);
      dispatch_src1_val = {$urandom, $urandom};
      dispatch_src2_val = {$urandom, $urandom};
      dispatch_src1_tag = TW'($urandom_range(0, 7));
      dispatch_src2_tag = TW'($urandom_range(0, 7));
      dispatch_dest_tag = TW'($urandom_range(0, 63));
      cdb_valid         = ($urandom_range(0, 1) == 1);
      cdb_tag           = TW'($urandom_range(0, 7));
      cdb_data          = {$urandom, $urandom};
      issue_ready       = ($urandom_range(0, 3) != 0);
    end
    tick(); idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
